// File: rtl/jtag_uart_stream_master.sv
// Avalon-MM master bridging byte streams to the JTAG UART data/control registers.
// Optional CR insertion before LF is enabled by defining JTAG_UART_STREAM_CRLF_EN.
module jtag_uart_stream_master #(
  parameter int TX_DEPTH      = 4,
  parameter int POLL_INTERVAL = 64
) (
  input  logic        clock_clk,
  input  logic        reset_reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        m_chipselect,
  output logic        m_address,
  output logic        m_read_n,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);
  // state   | meaning
  // IDLE    | pick next bus transaction, count down poll_timer
  // CTRL_RD | reading control register to refresh wspace_cnt
  // DATA_WR | writing one byte to the data register
  // DATA_RD | polling the data register for a received byte
  typedef enum logic [1:0] {IDLE, CTRL_RD, DATA_WR, DATA_RD} state_t;

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [15:0] POLL_LOAD = 16'(POLL_INTERVAL);

  state_t      state, state_nx;
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, fifo_nonempty, push, pop;
  logic [7:0]  fifo_head, wr_byte;
  logic [15:0] wspace_cnt, poll_timer;
  logic        last_tx, done;
  logic        wr_ok, ctrl_ok, rd_ok;
  logic        start_wr, start_ctrl, start_rd, start_any;
  logic        unused_readdata;

  assign unused_readdata = ^m_readdata[14:8];

  assign fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_nonempty = (wr_ptr != rd_ptr);
  assign fifo_head     = fifo_mem[rd_ptr[AW-1:0]];
  assign tx_ready      = !fifo_full;
  assign push          = tx_valid && tx_ready;
  assign done          = m_chipselect && !m_waitrequest;

`ifdef JTAG_UART_STREAM_CRLF_EN
  logic pending_lf, send_cr;
  // An LF at the head first goes out as CR; the LF stays queued until its own write.
  assign send_cr = (fifo_head == 8'h0A) && !pending_lf;
  assign wr_byte = send_cr ? 8'h0D : fifo_head;
  assign pop     = (state == DATA_WR) && done && !send_cr;

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)
      pending_lf <= 1'b0;
    else if (state == DATA_WR && done)
      pending_lf <= send_cr;
  end
`else
  assign wr_byte = fifo_head;
  assign pop     = (state == DATA_WR) && done;
`endif

  assign wr_ok   = fifo_nonempty && (wspace_cnt != 16'd0);
  assign ctrl_ok = fifo_nonempty && (wspace_cnt == 16'd0) && (poll_timer == 16'd0);
  assign rd_ok   = !rx_valid && (poll_timer == 16'd0);

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_wr   = 1'b0;
    start_ctrl = 1'b0;
    start_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok && rd_ok) begin
          start_rd = last_tx;
          start_wr = !last_tx;
        end else if (wr_ok)   start_wr   = 1'b1;
        else if (ctrl_ok)     start_ctrl = 1'b1;
        else if (rd_ok)       start_rd   = 1'b1;
        if (start_wr)        state_nx = DATA_WR;
        else if (start_ctrl) state_nx = CTRL_RD;
        else if (start_rd)   state_nx = DATA_RD;
      end
      default: if (done) state_nx = IDLE;
    endcase
  end

  assign start_any = start_wr || start_ctrl || start_rd;

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_chipselect <= 1'b0;
      m_address    <= 1'b0;
      m_read_n     <= 1'b1;
      m_write_n    <= 1'b1;
      m_writedata  <= 32'd0;
    end else if (start_wr) begin
      m_chipselect <= 1'b1;
      m_address    <= 1'b0;
      m_write_n    <= 1'b0;
      m_writedata  <= {24'd0, wr_byte};
    end else if (start_ctrl || start_rd) begin
      m_chipselect <= 1'b1;
      m_address    <= start_ctrl;
      m_read_n     <= 1'b0;
    end else if (done) begin
      m_chipselect <= 1'b0;
      m_read_n     <= 1'b1;
      m_write_n    <= 1'b1;
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wspace_cnt <= 16'd0;
      poll_timer <= 16'd0;
      rx_valid   <= 1'b0;
      rx_data    <= 8'd0;
      last_tx    <= 1'b0;
    end else begin
      if (state == CTRL_RD && done)      wspace_cnt <= m_readdata[31:16];
      else if (state == DATA_WR && done) wspace_cnt <= wspace_cnt - 16'd1;

      // An empty control read or an empty data read both back off the poller.
      if (state == CTRL_RD && done && m_readdata[31:16] == 16'd0)
        poll_timer <= POLL_LOAD;
      else if (state == DATA_RD && done && !m_readdata[15])
        poll_timer <= POLL_LOAD;
      else if (state == IDLE && !start_any && poll_timer != 16'd0)
        poll_timer <= poll_timer - 16'd1;

      if (state == DATA_RD && done && m_readdata[15]) begin
        rx_data  <= m_readdata[7:0];
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (start_wr)      last_tx <= 1'b1;
      else if (start_rd) last_tx <= 1'b0;
    end
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock_clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= tx_data;
  end
endmodule

// File: tb/tb_jtag_uart_stream_master.sv
// Self-checking bench: behavioural JTAG UART slave plus scoreboards for TX writes and RX bytes.
module tb_jtag_uart_stream_master;
  logic        clock_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        m_chipselect, m_address, m_read_n, m_write_n;
  logic [31:0] m_writedata, m_readdata;
  logic        m_waitrequest;

  logic [31:0] ctrl_word = 32'h0040_0000;
  logic [31:0] data_word = 32'd0;
  logic        stall_writes = 1'b0;
  logic        clr_data = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [31:0] exp_wr [$];
  logic [7:0]  exp_rx [$];
  logic [32:0] obs_wr [$];
  int          wr_cyc [$];
  int          ctrl_cyc [$];
  int          rd_cyc [$];

  jtag_uart_stream_master dut (
    .clock_clk    (clock_clk),
    .reset_reset_n(reset_reset_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .m_chipselect (m_chipselect),
    .m_address    (m_address),
    .m_read_n     (m_read_n),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  always #5 clock_clk = ~clock_clk;
  always @(posedge clock_clk) cyc++;

  assign m_readdata    = m_address ? ctrl_word : data_word;
  assign m_waitrequest = stall_writes & m_chipselect & ~m_write_n;

  // Slave side: record each completed transaction; an RVALID data word is handed out once.
  always @(negedge clock_clk) begin
    if (reset_reset_n && m_chipselect && !m_waitrequest) begin
      if (!m_write_n) begin
        obs_wr.push_back({m_address, m_writedata});
        wr_cyc.push_back(cyc);
      end else if (m_address) begin
        ctrl_cyc.push_back(cyc);
      end else begin
        rd_cyc.push_back(cyc);
        if (m_readdata[15]) clr_data = 1'b1;
      end
    end
  end

  always begin
    @(posedge clock_clk);
    #1;
    if (clr_data) begin
      data_word = 32'd0;
      clr_data  = 1'b0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_wr.delete(); wr_cyc.delete(); ctrl_cyc.delete(); rd_cyc.delete(); exp_wr.delete();
  endtask

  task automatic do_reset();
    tx_valid = 1'b0;
    reset_reset_n = 1'b0;
    tick(2);
    reset_reset_n = 1'b1;
    tick(1);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit exp_on, input int budget, output bit ok);
    ok = 1'b0;
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock_clk);
      if (tx_ready) ok = 1'b1;
      @(posedge clock_clk);
      #1;
    end
    tx_valid = 1'b0;
    if (ok && exp_on) begin
`ifdef JTAG_UART_STREAM_CRLF_EN
      if (b == 8'h0A) exp_wr.push_back(32'h0000_000D);
`endif
      exp_wr.push_back({24'd0, b});
    end
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (obs_wr.size() >= n) ok = 1'b1;
      else tick(1);
    end
  endtask

  task automatic test_reset();
    bit ok;
    bit seen;
    tick(2);
    @(negedge clock_clk);
    n_cmp++;
    if ({m_chipselect, m_read_n, m_write_n, m_address} !== 4'b0110) begin
      n_bad++;
      $display("FAIL reset_strobes: got cs/rd_n/wr_n/addr=%b want 0110",
               {m_chipselect, m_read_n, m_write_n, m_address});
    end
    n_cmp++;
    if (m_writedata !== 32'd0) begin
      n_bad++; $display("FAIL reset_writedata: got %h want 00000000", m_writedata);
    end
    n_cmp++;
    if ({rx_valid, rx_data} !== 9'd0) begin
      n_bad++; $display("FAIL reset_rx: got valid=%b data=%h want 0/00", rx_valid, rx_data);
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready);
    end
    tick(1);
    reset_reset_n = 1'b1;
    tick(1);
    stall_writes = 1'b1;
    push_byte(8'h33, 1'b0, 10, ok);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock_clk);
      if (m_chipselect && !m_write_n) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++; $display("FAIL midwr_start: got write_seen=%b want 1", seen);
    end
    @(negedge clock_clk);
    #2;
    reset_reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_chipselect, m_read_n, m_write_n} !== 3'b011) begin
      n_bad++;
      $display("FAIL midwr_reset_strobes: got cs/rd_n/wr_n=%b want 011", {m_chipselect, m_read_n, m_write_n});
    end
    stall_writes = 1'b0;
    tick(3);
    reset_reset_n = 1'b1;
    clear_logs();
    tick(150);
    n_cmp++;
    if ({tx_ready, rx_valid} !== 2'b10) begin
      n_bad++; $display("FAIL post_reset_ready: got tx_ready/rx_valid=%b want 10", {tx_ready, rx_valid});
    end
    n_cmp++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL no_reissue: got %0d writes want 0", obs_wr.size());
    end
  endtask

  task automatic test_ctrl_then_write();
    bit ok;
    logic [32:0] got;
    logic [31:0] want;
    clear_logs();
    ctrl_word = 32'h0040_0000;
    push_byte(8'h41, 1'b1, 10, ok);
    wait_writes(1, 300, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL ctrl_wr_timeout: got %0d writes want 1", obs_wr.size());
    end
    if (ok) begin
      n_cmp++;
      if (!(ctrl_cyc.size() > 0 && ctrl_cyc[0] < wr_cyc[0])) begin
        n_bad++; $display("FAIL ctrl_before_write: got %0d ctrl reads before write want >=1", ctrl_cyc.size());
      end
      got  = obs_wr.pop_front();
      want = exp_wr.pop_front();
      n_cmp++;
      if (got !== {1'b0, want}) begin
        n_bad++; $display("FAIL ctrl_wr_data: got addr/data=%h want %h", got, {1'b0, want});
      end
    end
    tick(3);
    n_cmp++;
    if (dut.wspace_cnt !== 16'd63) begin
      n_bad++; $display("FAIL wspace_after_one: got %0d want 63", dut.wspace_cnt);
    end
    tick(100);
    n_cmp++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL fifo_drained: got %0d extra writes want 0", obs_wr.size());
    end
  endtask

  task automatic test_waitrequest();
    bit ok;
    bit seen;
    logic        a0;
    logic [31:0] d0;
    logic [32:0] got;
    logic [31:0] want;
    clear_logs();
    stall_writes = 1'b1;
    push_byte(8'h42, 1'b1, 10, ok);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock_clk);
      if (m_chipselect && !m_write_n) seen = 1'b1;
    end
    a0 = m_address;
    d0 = m_writedata;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_clk);
      n_cmp++;
      if ({m_chipselect, m_write_n, m_address, m_writedata} !== {1'b1, 1'b0, a0, d0}) begin
        n_bad++;
        $display("FAIL stall_stable: got cs/wr_n/addr/data=%b/%b/%b/%h want 1/0/%b/%h",
                 m_chipselect, m_write_n, m_address, m_writedata, a0, d0);
      end
    end
    @(posedge clock_clk);
    #1;
    stall_writes = 1'b0;
    wait_writes(1, 20, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL stall_wr_timeout: got %0d writes want 1", obs_wr.size());
    end
    if (ok) begin
      got  = obs_wr.pop_front();
      want = exp_wr.pop_front();
      n_cmp++;
      if (got !== {1'b0, want}) begin
        n_bad++; $display("FAIL stall_wr_data: got addr/data=%h want %h", got, {1'b0, want});
      end
    end
    tick(3);
    n_cmp++;
    if (dut.wspace_cnt !== 16'd62) begin
      n_bad++; $display("FAIL stall_single_decrement: got %0d want 62", dut.wspace_cnt);
    end
    tick(50);
    n_cmp++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL stall_single_pop: got %0d extra writes want 0", obs_wr.size());
    end
  endtask

  task automatic test_rx();
    bit seen;
    int gap;
    rx_ready = 1'b0;
    exp_rx.push_back(8'h55);
    data_word = 32'h0001_8055;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock_clk);
      if (rx_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_bad++; $display("FAIL rx_timeout: got rx_valid=%b want 1", rx_valid);
    end
    n_cmp++;
    if (rx_data !== exp_rx.pop_front()) begin
      n_bad++; $display("FAIL rx_data: got %h want 55", rx_data);
    end
    tick(1);
    rd_cyc.delete();
    tick(100);
    n_cmp++;
    if ({rx_valid, rd_cyc.size() == 0} !== 2'b11) begin
      n_bad++; $display("FAIL rx_hold: got rx_valid=%b reads=%0d want 1/0", rx_valid, rd_cyc.size());
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    @(negedge clock_clk);
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL rx_clear: got rx_valid=%b want 0", rx_valid);
    end
    tick(1);
    for (int i = 0; i < 300 && rd_cyc.size() < 2; i++) tick(1);
    gap = (rd_cyc.size() >= 2) ? rd_cyc[1] - rd_cyc[0] : -1;
    n_cmp++;
    if (gap < 64 || gap > 80) begin
      n_bad++; $display("FAIL poll_interval: got gap=%0d cycles want 64..80", gap);
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit all_ok;
    int early;
    logic [32:0] got;
    logic [31:0] want;
    do_reset();
    ctrl_word = 32'h0000_0000;
    clear_logs();
    all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h51 + 8'(i), 1'b1, 10, ok);
      all_ok &= ok;
    end
    n_cmp++;
    if (all_ok !== 1'b1) begin
      n_bad++; $display("FAIL full_pushes: got all_accepted=%b want 1", all_ok);
    end
    @(negedge clock_clk);
    n_cmp++;
    if (tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL full_tx_ready: got %b want 0", tx_ready);
    end
    tick(1);
    tx_data = 8'h55;
    tx_valid = 1'b1;
    early = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock_clk);
      if (tx_ready) early++;
    end
    n_cmp++;
    if (early !== 0 || obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL full_holdoff: got ready_cycles=%0d writes=%0d want 0/0", early, obs_wr.size());
    end
    n_cmp++;
    if (ctrl_cyc.size() < 1) begin
      n_bad++; $display("FAIL full_ctrl_poll: got %0d control reads want >=1", ctrl_cyc.size());
    end
    tick(1);
    ctrl_word = 32'h0040_0000;
    push_byte(8'h55, 1'b1, 400, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL full_fifth_push: got accepted=%b want 1", ok);
    end
    wait_writes(5, 400, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL full_drain_timeout: got %0d writes want 5", obs_wr.size());
    end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got  = obs_wr.pop_front();
      want = exp_wr.pop_front();
      n_cmp++;
      if (got !== {1'b0, want}) begin
        n_bad++; $display("FAIL full_order: got addr/data=%h want %h", got, {1'b0, want});
      end
    end
  endtask

  task automatic test_crlf();
    bit ok;
    int n_exp;
    logic [32:0] got;
    logic [31:0] want;
    do_reset();
    ctrl_word = 32'h0040_0000;
    clear_logs();
    push_byte(8'h0A, 1'b1, 10, ok);
    n_exp = exp_wr.size();
    wait_writes(n_exp, 300, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_bad++; $display("FAIL lf_timeout: got %0d writes want %0d", obs_wr.size(), n_exp);
    end
    for (int i = 0; i < n_exp && obs_wr.size() > 0; i++) begin
      got  = obs_wr.pop_front();
      want = exp_wr.pop_front();
      n_cmp++;
      if (got !== {1'b0, want}) begin
        n_bad++; $display("FAIL lf_write%0d: got addr/data=%h want %h", i, got, {1'b0, want});
      end
    end
    tick(50);
    n_cmp++;
    if (dut.wspace_cnt !== 16'(64 - n_exp)) begin
      n_bad++; $display("FAIL lf_wspace: got %0d want %0d", dut.wspace_cnt, 64 - n_exp);
    end
    n_cmp++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL lf_extra: got %0d extra writes want 0", obs_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_then_write();
    test_waitrequest();
    test_rx();
    test_fifo_full();
    test_crlf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
